// File: rtl/ysyx_22041071_ram_arbiter_pkg.sv
// Shared definitions for the RAMHelper arbiter: FSM states, requester IDs,
// access-size encodings and the byte-lane mask helper.
package ysyx_22041071_ram_arbiter_pkg;

  localparam logic [63:0] BASE_ADDR_DEF = 64'h0000_0000_8000_0000;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // Unshifted bit mask covering the bytes touched by an access of this size.
  function automatic logic [63:0] lane_mask(input logic [1:0] size);
    case (size)
      SZ_B:    lane_mask = 64'h0000_0000_0000_00FF;
      SZ_H:    lane_mask = 64'h0000_0000_0000_FFFF;
      SZ_W:    lane_mask = 64'h0000_0000_FFFF_FFFF;
      default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22041071_wmask_gen.sv
// Combinational store formatter: positions the write mask and data on the
// byte lanes selected by addr[2:0] and flags accesses not aligned to their size.
module ysyx_22041071_wmask_gen
  import ysyx_22041071_ram_arbiter_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_addr_lo,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_wmask,
  output logic [63:0] o_wdata,
  output logic        o_misalign
);

  logic [5:0] w_shamt;

  assign w_shamt = {i_addr_lo, 3'b000};
  assign o_wmask = lane_mask(i_size) << w_shamt;
  assign o_wdata = i_wdata << w_shamt;

  // An access is aligned when the low log2(size) address bits are zero.
  always_comb begin
    case (i_size)
      SZ_B:    o_misalign = 1'b0;
      SZ_H:    o_misalign = i_addr_lo[0];
      SZ_W:    o_misalign = |i_addr_lo[1:0];
      default: o_misalign = |i_addr_lo;
    endcase
  end

endmodule

// File: rtl/ysyx_22041071_ram_arbiter.sv
// Round-robin arbiter sharing the single RAMHelper port between IF and MEM,
// with one outstanding transaction and a fixed RD_LAT+2 cycle turnaround.
module ysyx_22041071_ram_arbiter
  import ysyx_22041071_ram_arbiter_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int          RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [63:0] if_resp_data,

  input  logic        mem_req_valid,
  output logic        mem_req_ready,
  input  logic [63:0] mem_addr,
  input  logic        mem_wen,
  input  logic [1:0]  mem_size,
  input  logic [63:0] mem_wdata,
  output logic        mem_resp_valid,
  output logic [63:0] mem_resp_data,
  output logic        mem_resp_err,

  output logic        ram_en,
  output logic [63:0] ram_ridx,
  input  logic [63:0] ram_rdata,
  output logic [63:0] ram_widx,
  output logic [63:0] ram_wdata,
  output logic [63:0] ram_wmask,
  output logic        ram_wen
);

  localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

  state_e      r_state;
  req_e        r_req_id;
  req_e        r_last_grant;
  logic        r_wen;
  logic [1:0]  r_cnt;

  logic        r_ram_en;
  logic        r_ram_wen;
  logic [63:0] r_ram_ridx;
  logic [63:0] r_ram_widx;
  logic [63:0] r_ram_wdata;
  logic [63:0] r_ram_wmask;
  logic        r_if_resp_valid;
  logic [63:0] r_if_resp_data;
  logic        r_mem_resp_valid;
  logic [63:0] r_mem_resp_data;
  logic        r_mem_resp_err;

  logic        w_window;
  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_accept;
  logic [63:0] w_sel_addr;
  logic [1:0]  w_sel_size;
  logic        w_sel_wen;
  logic [63:0] w_word_idx;
  logic [63:0] w_wmask;
  logic [63:0] w_wdata;
  logic        w_misalign;
  logic        w_err;

  // On a tie the requester that did not win last time takes the port.
  assign w_window    = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_grant_if  = if_req_valid  && (!mem_req_valid || (r_last_grant == REQ_MEM));
  assign w_grant_mem = mem_req_valid && (!if_req_valid  || (r_last_grant == REQ_IF));

  assign if_req_ready  = w_window && w_grant_if;
  assign mem_req_ready = w_window && w_grant_mem;
  assign w_accept      = if_req_ready || mem_req_ready;

  assign w_sel_addr = mem_req_ready ? mem_addr : if_addr;
  assign w_sel_size = mem_req_ready ? mem_size : SZ_D;
  assign w_sel_wen  = mem_req_ready && mem_wen;
  assign w_word_idx = (w_sel_addr - BASE_ADDR) >> 3;

  ysyx_22041071_wmask_gen u_wmask_gen (
    .i_size     (w_sel_size),
    .i_addr_lo  (w_sel_addr[2:0]),
    .i_wdata    (mem_wdata),
    .o_wmask    (w_wmask),
    .o_wdata    (w_wdata),
    .o_misalign (w_misalign)
  );

  assign w_err = mem_req_ready && (w_misalign || (mem_addr < BASE_ADDR));

  // Transaction FSM; every RAM and response output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_req_id         <= REQ_IF;
      r_last_grant     <= REQ_MEM;
      r_wen            <= 1'b0;
      r_cnt            <= 2'd0;
      r_ram_en         <= 1'b0;
      r_ram_wen        <= 1'b0;
      r_ram_ridx       <= 64'h0;
      r_ram_widx       <= 64'h0;
      r_ram_wdata      <= 64'h0;
      r_ram_wmask      <= 64'h0;
      r_if_resp_valid  <= 1'b0;
      r_if_resp_data   <= 64'h0;
      r_mem_resp_valid <= 1'b0;
      r_mem_resp_data  <= 64'h0;
      r_mem_resp_err   <= 1'b0;
    end else begin
      r_ram_en         <= 1'b0;
      r_ram_wen        <= 1'b0;
      r_ram_wdata      <= 64'h0;
      r_ram_wmask      <= 64'h0;
      r_if_resp_valid  <= 1'b0;
      r_if_resp_data   <= 64'h0;
      r_mem_resp_valid <= 1'b0;
      r_mem_resp_data  <= 64'h0;
      r_mem_resp_err   <= 1'b0;

      case (r_state)
        ST_IDLE, ST_RESP: begin
          if (w_accept) begin
            r_req_id     <= mem_req_ready ? REQ_MEM : REQ_IF;
            r_last_grant <= mem_req_ready ? REQ_MEM : REQ_IF;
            r_wen        <= w_sel_wen;
            if (w_err) begin
              // Rejected accesses never touch the RAM and answer next cycle.
              r_state          <= ST_RESP;
              r_mem_resp_valid <= 1'b1;
              r_mem_resp_err   <= 1'b1;
            end else begin
              r_state    <= ST_ISSUE;
              r_ram_ridx <= w_word_idx;
              r_ram_widx <= w_word_idx;
              if (w_sel_wen) begin
                r_ram_wen   <= 1'b1;
                r_ram_wmask <= w_wmask;
                r_ram_wdata <= w_wdata;
              end else begin
                r_ram_en <= 1'b1;
              end
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end

        ST_ISSUE: begin
          r_cnt   <= 2'd0;
          r_state <= ST_WAIT;
        end

        ST_WAIT: begin
          if (r_cnt == LAT_LAST) begin
            r_state <= ST_RESP;
            if (r_req_id == REQ_IF) begin
              r_if_resp_valid <= 1'b1;
              r_if_resp_data  <= ram_rdata;
            end else begin
              r_mem_resp_valid <= 1'b1;
              r_mem_resp_data  <= r_wen ? 64'h0 : ram_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ram_en         = r_ram_en;
  assign ram_wen        = r_ram_wen;
  assign ram_ridx       = r_ram_ridx;
  assign ram_widx       = r_ram_widx;
  assign ram_wdata      = r_ram_wdata;
  assign ram_wmask      = r_ram_wmask;
  assign if_resp_valid  = r_if_resp_valid;
  assign if_resp_data   = r_if_resp_data;
  assign mem_resp_valid = r_mem_resp_valid;
  assign mem_resp_data  = r_mem_resp_data;
  assign mem_resp_err   = r_mem_resp_err;

endmodule

// File: tb/tb_ysyx_22041071_ram_arbiter.sv
// Directed self-checking bench: an RD_LAT=1 instance with a small RAM model
// and an RD_LAT=3 instance for latency and back-to-back acceptance.
module tb_ysyx_22041071_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // RD_LAT = 1 instance signals
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_addr, if_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr, mem_wdata, mem_resp_data;
  logic        ram_en, ram_wen;
  logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

  // RD_LAT = 3 instance signals
  logic        if_req_valid_3, if_req_ready_3, if_resp_valid_3;
  logic [63:0] if_addr_3, if_resp_data_3;
  logic        mem_req_valid_3, mem_req_ready_3, mem_wen_3, mem_resp_valid_3, mem_resp_err_3;
  logic [1:0]  mem_size_3;
  logic [63:0] mem_addr_3, mem_wdata_3, mem_resp_data_3;
  logic        ram_en_3, ram_wen_3;
  logic [63:0] ram_ridx_3, ram_rdata_3, ram_widx_3, ram_wdata_3, ram_wmask_3;

  ysyx_22041071_ram_arbiter #(.BASE_ADDR(64'h8000_0000), .RD_LAT(1)) u_dut (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_size(mem_size), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_rdata(ram_rdata), .ram_widx(ram_widx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_wen(ram_wen)
  );

  ysyx_22041071_ram_arbiter #(.BASE_ADDR(64'h8000_0000), .RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req_valid(if_req_valid_3), .if_req_ready(if_req_ready_3), .if_addr(if_addr_3),
    .if_resp_valid(if_resp_valid_3), .if_resp_data(if_resp_data_3),
    .mem_req_valid(mem_req_valid_3), .mem_req_ready(mem_req_ready_3), .mem_addr(mem_addr_3),
    .mem_wen(mem_wen_3), .mem_size(mem_size_3), .mem_wdata(mem_wdata_3),
    .mem_resp_valid(mem_resp_valid_3), .mem_resp_data(mem_resp_data_3), .mem_resp_err(mem_resp_err_3),
    .ram_en(ram_en_3), .ram_ridx(ram_ridx_3), .ram_rdata(ram_rdata_3), .ram_widx(ram_widx_3),
    .ram_wdata(ram_wdata_3), .ram_wmask(ram_wmask_3), .ram_wen(ram_wen_3)
  );

  // RAM model for the RD_LAT=1 instance: read index latched on ram_en,
  // masked writes on ram_wen, preloaded on reset.
  logic [63:0] ram [0:15];
  logic [63:0] r_ridx_q;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 64'h0;
      ram[2]   <= 64'h1122_3344_5566_7788;
      ram[3]   <= 64'h3333_3333_3333_3333;
      ram[4]   <= 64'h4444_4444_4444_4444;
      r_ridx_q <= 64'h0;
    end else begin
      if (ram_en) r_ridx_q <= ram_ridx;
      if (ram_wen) ram[ram_widx[3:0]] <= (ram[ram_widx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
    end
  end
  assign ram_rdata = ram[r_ridx_q[3:0]];

  // RAM model for the RD_LAT=3 instance: word content is a tagged index.
  logic [63:0] r_ridx3_q;
  always @(posedge clk) begin
    if (reset) r_ridx3_q <= 64'h0;
    else if (ram_en_3) r_ridx3_q <= ram_ridx_3;
  end
  assign ram_rdata_3 = 64'hC0DE_0000_0000_0000 | r_ridx3_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_if(input logic [63:0] addr, input logic [63:0] idx, input logic [63:0] data);
    @(negedge clk);
    if_req_valid = 1'b1;
    if_addr      = addr;
    #1;
    check("if_ready", {63'h0, if_req_ready}, 64'h1);
    check("if_mem_ready_low", {63'h0, mem_req_ready}, 64'h0);
    @(negedge clk);
    if_req_valid = 1'b0;
    check("if_ram_en", {63'h0, ram_en}, 64'h1);
    check("if_ridx", ram_ridx, idx);
    @(negedge clk);
    check("if_ram_en_pulse", {63'h0, ram_en}, 64'h0);
    check("if_resp_early", {63'h0, if_resp_valid}, 64'h0);
    @(negedge clk);
    check("if_resp_valid", {63'h0, if_resp_valid}, 64'h1);
    check("if_resp_data", if_resp_data, data);
    @(negedge clk);
    check("if_resp_pulse", {63'h0, if_resp_valid}, 64'h0);
  endtask

  task automatic do_mem(input logic [63:0] addr, input logic wen, input logic [1:0] size,
                        input logic [63:0] wdata, input logic exp_err, input logic [63:0] idx,
                        input logic [63:0] exp_mask, input logic [63:0] exp_wd,
                        input logic [63:0] exp_data);
    @(negedge clk);
    mem_req_valid = 1'b1;
    mem_addr      = addr;
    mem_wen       = wen;
    mem_size      = size;
    mem_wdata     = wdata;
    #1;
    check("mem_ready", {63'h0, mem_req_ready}, 64'h1);
    @(negedge clk);
    mem_req_valid = 1'b0;
    if (exp_err) begin
      check("err_resp_valid", {63'h0, mem_resp_valid}, 64'h1);
      check("err_flag", {63'h0, mem_resp_err}, 64'h1);
      check("err_data", mem_resp_data, 64'h0);
      check("err_no_ram_en", {63'h0, ram_en}, 64'h0);
      check("err_no_ram_wen", {63'h0, ram_wen}, 64'h0);
      @(negedge clk);
      check("err_resp_pulse", {63'h0, mem_resp_valid}, 64'h0);
      check("err_no_ram_en2", {63'h0, ram_en}, 64'h0);
      check("err_no_ram_wen2", {63'h0, ram_wen}, 64'h0);
    end else begin
      check("mem_ram_en", {63'h0, ram_en}, {63'h0, ~wen});
      check("mem_ram_wen", {63'h0, ram_wen}, {63'h0, wen});
      check("mem_ridx", ram_ridx, idx);
      check("mem_widx", ram_widx, idx);
      if (wen) begin
        check("mem_wmask", ram_wmask, exp_mask);
        check("mem_wdata", ram_wdata, exp_wd);
      end
      @(negedge clk);
      check("mem_ram_pulse", {62'h0, ram_en, ram_wen}, 64'h0);
      check("mem_resp_early", {63'h0, mem_resp_valid}, 64'h0);
      @(negedge clk);
      check("mem_resp_valid", {63'h0, mem_resp_valid}, 64'h1);
      check("mem_resp_err", {63'h0, mem_resp_err}, 64'h0);
      check("mem_resp_data", mem_resp_data, exp_data);
      @(negedge clk);
      check("mem_resp_pulse", {63'h0, mem_resp_valid}, 64'h0);
    end
  endtask

  initial begin
    int       n_grant;
    int       n_if_resp;
    int       n_mem_resp;
    int       n_pulse;
    logic [5:0] grant_seq;

    reset = 1'b1;
    if_req_valid = 1'b0;   if_addr = 64'h0;
    mem_req_valid = 1'b0;  mem_addr = 64'h0;  mem_wen = 1'b0;  mem_size = 2'd0;  mem_wdata = 64'h0;
    if_req_valid_3 = 1'b0; if_addr_3 = 64'h0;
    mem_req_valid_3 = 1'b0; mem_addr_3 = 64'h0; mem_wen_3 = 1'b0; mem_size_3 = 2'd0; mem_wdata_3 = 64'h0;

    repeat (2) @(negedge clk);
    check("rst_ram_en", {63'h0, ram_en}, 64'h0);
    check("rst_ram_wen", {63'h0, ram_wen}, 64'h0);
    check("rst_wmask", ram_wmask, 64'h0);
    check("rst_ridx", ram_ridx, 64'h0);
    check("rst_resp", {62'h0, if_resp_valid, mem_resp_valid}, 64'h0);
    reset = 1'b0;

    do_if(64'h8000_0010, 64'd2, 64'h1122_3344_5566_7788);
    do_mem(64'h8000_0006, 1'b1, 2'd1, 64'hABCD, 1'b0, 64'd0,
           64'hFFFF_0000_0000_0000, 64'hABCD_0000_0000_0000, 64'h0);
    do_mem(64'h8000_0005, 1'b1, 2'd1, 64'hABCD, 1'b1, 64'd0, 64'h0, 64'h0, 64'h0);
    do_mem(64'h8000_0000, 1'b0, 2'd3, 64'h0, 1'b0, 64'd0, 64'h0, 64'h0, 64'hABCD_0000_0000_0000);
    do_mem(64'h8000_0013, 1'b1, 2'd0, 64'h5A, 1'b0, 64'd2,
           64'h0000_0000_FF00_0000, 64'h0000_0000_5A00_0000, 64'h0);
    do_mem(64'h8000_0010, 1'b0, 2'd3, 64'h0, 1'b0, 64'd2, 64'h0, 64'h0, 64'h1122_3344_5A66_7788);
    do_mem(64'h8000_0003, 1'b0, 2'd2, 64'h0, 1'b1, 64'd0, 64'h0, 64'h0, 64'h0);
    do_mem(64'h7FFF_FFF8, 1'b0, 2'd3, 64'h0, 1'b1, 64'd0, 64'h0, 64'h0, 64'h0);

    // Round-robin: both requesters valid until six grants have been taken.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    if_req_valid = 1'b1;  if_addr = 64'h8000_0018;
    mem_req_valid = 1'b1; mem_addr = 64'h8000_0020; mem_wen = 1'b0; mem_size = 2'd3;
    n_grant = 0; n_if_resp = 0; n_mem_resp = 0; grant_seq = 6'h0;
    for (int c = 0; c < 40; c++) begin
      if (c != 0) @(negedge clk);
      if (n_grant == 6) begin
        if_req_valid  = 1'b0;
        mem_req_valid = 1'b0;
      end
      #1;
      if (if_resp_valid) begin
        n_if_resp++;
        check("rr_if_data", if_resp_data, 64'h3333_3333_3333_3333);
      end
      if (mem_resp_valid) begin
        n_mem_resp++;
        check("rr_mem_data", mem_resp_data, 64'h4444_4444_4444_4444);
      end
      if (n_grant < 6 && (if_req_ready || mem_req_ready)) begin
        grant_seq[n_grant] = mem_req_ready;
        n_grant++;
      end
    end
    check("rr_grant_count", 64'(n_grant), 64'd6);
    check("rr_grant_order", {58'h0, grant_seq}, 64'h0000_0000_0000_002A);
    check("rr_if_resp_count", 64'(n_if_resp), 64'd3);
    check("rr_mem_resp_count", 64'(n_mem_resp), 64'd3);

    // Reset during WAIT of a store drops it without a response.
    @(negedge clk);
    mem_req_valid = 1'b1; mem_addr = 64'h8000_0008; mem_wen = 1'b1; mem_size = 2'd3;
    mem_wdata = 64'h1234_5678_9ABC_DEF0;
    #1;
    check("rw_ready", {63'h0, mem_req_ready}, 64'h1);
    @(negedge clk);
    mem_req_valid = 1'b0;
    check("rw_ram_wen", {63'h0, ram_wen}, 64'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_pulse = 0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (mem_resp_valid || ram_wen) n_pulse++;
    end
    check("rw_no_resp_after_reset", 64'(n_pulse), 64'd0);
    do_if(64'h8000_0010, 64'd2, 64'h1122_3344_5566_7788);

    // RD_LAT = 3: response at T+5, next request accepted in that RESP cycle.
    @(negedge clk);
    if_req_valid_3 = 1'b1; if_addr_3 = 64'h8000_0008;
    #1;
    check("l3_if_ready", {63'h0, if_req_ready_3}, 64'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if_req_valid_3 = 1'b0;
        check("l3_ram_en", {63'h0, ram_en_3}, 64'h1);
        check("l3_ridx", ram_ridx_3, 64'd1);
      end else if (k < 5) begin
        check("l3_no_resp", {63'h0, if_resp_valid_3}, 64'h0);
        check("l3_ram_en_low", {63'h0, ram_en_3}, 64'h0);
      end else begin
        check("l3_resp_valid", {63'h0, if_resp_valid_3}, 64'h1);
        check("l3_resp_data", if_resp_data_3, 64'hC0DE_0000_0000_0001);
        mem_req_valid_3 = 1'b1; mem_addr_3 = 64'h8000_0030; mem_wen_3 = 1'b0; mem_size_3 = 2'd3;
        #1;
        check("l3_b2b_ready", {63'h0, mem_req_ready_3}, 64'h1);
      end
    end
    @(negedge clk);
    mem_req_valid_3 = 1'b0;
    check("l3_b2b_ram_en", {63'h0, ram_en_3}, 64'h1);
    check("l3_b2b_ridx", ram_ridx_3, 64'd6);
    repeat (4) @(negedge clk);
    check("l3_b2b_resp_valid", {63'h0, mem_resp_valid_3}, 64'h1);
    check("l3_b2b_resp_data", mem_resp_data_3, 64'hC0DE_0000_0000_0006);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
